// File: rtl/comp_pkg.sv
// ----------------------------------------------------------------------------
// comp_pkg
// Shared definitions for the computation datapath blocks.
//   ADDR_W / DATA_W : shared SRAM address and data widths (64x8 memory)
//   N_RES / IDX_W   : results per writeback transfer and the beat index width
//   wb_state_t      : result_writeback FSM states (2-bit encoding)
// ----------------------------------------------------------------------------
package comp_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int N_RES  = 4;
    localparam int IDX_W  = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CAPT  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } wb_state_t;

endpackage

// File: rtl/result_shadow_regs.sv
// ----------------------------------------------------------------------------
// result_shadow_regs
// Holds a snapshot of the four compute results so the writeback is immune to
// the compute mode changing its outputs while the transfer is in flight.
// Ports:
//   clk, rst      : clock, synchronous active-low reset (clears all entries)
//   load_i        : capture d0_i..d3_i into entries 0..3
//   d0_i..d3_i    : results in fixed order c11, c12, c21, c22
//   idx_i         : read select
//   q_o           : entry selected by idx_i
// ----------------------------------------------------------------------------
module result_shadow_regs
    import comp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] d0_i,
    input  logic [DATA_W-1:0] d1_i,
    input  logic [DATA_W-1:0] d2_i,
    input  logic [DATA_W-1:0] d3_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] shadow_q [N_RES];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_RES; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (load_i) begin
            shadow_q[0] <= d0_i;
            shadow_q[1] <= d1_i;
            shadow_q[2] <= d2_i;
            shadow_q[3] <= d3_i;
        end
    end

    assign q_o = shadow_q[idx_i];

endmodule

// File: rtl/result_writeback.sv
// ----------------------------------------------------------------------------
// result_writeback
// Writes the four results of a compute mode into the shared SRAM, one beat per
// granted cycle, at consecutive addresses starting from a base (mod 2**ADDR_W).
// Handshake: while we=1 the beat (addr,data) is offered; it is accepted in any
// cycle where gnt=1 and held unchanged in every cycle where gnt=0.
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   en                : level start/hold from the top FSM
//   result_baseaddr   : first write address, sampled in S_CAPT
//   c11,c12,c21,c22   : results, sampled in S_CAPT
//   gnt               : memory grant from the arbiter
//   addr, we, data    : memory write port
//   busy              : transfer in progress (S_CAPT / S_WRITE)
//   is_done_o         : transfer complete, held until en drops
//   dbg_state_o       : current FSM state
// All outputs decode registered state only; no input-to-output path.
// ----------------------------------------------------------------------------
module result_writeback
    import comp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] result_baseaddr,
    input  logic [DATA_W-1:0] c11,
    input  logic [DATA_W-1:0] c12,
    input  logic [DATA_W-1:0] c21,
    input  logic [DATA_W-1:0] c22,
    input  logic              gnt,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              is_done_o,
    output wb_state_t         dbg_state_o
);

    wb_state_t         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              load;
    logic [DATA_W-1:0] shadow_rd;

    result_shadow_regs u_shadow (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .d0_i   (c11),
        .d1_i   (c12),
        .d2_i   (c21),
        .d3_i   (c22),
        .idx_i  (idx_q),
        .q_o    (shadow_rd)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        load    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (en) state_d = S_CAPT;
            end
            S_CAPT: begin
                // Dropping en here discards the capture entirely.
                if (en) begin
                    load    = 1'b1;
                    base_d  = result_baseaddr;
                    idx_d   = '0;
                    state_d = S_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                // Abort has priority; a granted beat in the abort cycle is
                // still written by the memory, we simply stop afterwards.
                if (!en) begin
                    state_d = S_IDLE;
                end else if (gnt) begin
                    // idx stays at the last beat so S_DONE keeps showing it.
                    if (idx_q == IDX_W'(N_RES - 1)) state_d = S_DONE;
                    else                            idx_d   = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (!en) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic show_beat;
    assign show_beat   = (state_q == S_WRITE) || (state_q == S_DONE);

    assign we          = (state_q == S_WRITE);
    assign busy        = (state_q == S_CAPT) || (state_q == S_WRITE);
    assign is_done_o   = (state_q == S_DONE);
    assign addr        = show_beat ? base_q + ADDR_W'(idx_q) : '0;
    assign data        = show_beat ? shadow_rd : '0;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_result_writeback.sv
module tb_result_writeback;
  import comp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, gnt;
  logic [5:0]  result_baseaddr;
  logic [7:0]  c11, c12, c21, c22;
  logic [5:0]  addr;
  logic        we;
  logic [7:0]  data;
  logic        busy, is_done_o;
  wb_state_t   dbg_state;

  result_writeback dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .result_baseaddr (result_baseaddr),
    .c11             (c11),
    .c12             (c12),
    .c21             (c21),
    .c22             (c22),
    .gnt             (gnt),
    .addr            (addr),
    .we              (we),
    .data            (data),
    .busy            (busy),
    .is_done_o       (is_done_o),
    .dbg_state_o     (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [13:0] exp_q[$];   // {addr, data} of each expected write beat

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst === 1'b1 && we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h expected no write", addr, data);
      end else if (gnt === 1'b1) begin
        logic [13:0] e;
        e = exp_q.pop_front();
        chk("beat", {18'd0, addr, data}, {18'd0, e});
      end else begin
        chk("stall_hold", {18'd0, addr, data}, {18'd0, exp_q[0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_xfer(input logic [5:0] b, input logic [7:0] a0, input logic [7:0] a1,
                           input logic [7:0] a2, input logic [7:0] a3);
    logic [5:0] ad;
    ad = b;        exp_q.push_back({ad, a0});
    ad = b + 6'd1; exp_q.push_back({ad, a1});
    ad = b + 6'd2; exp_q.push_back({ad, a2});
    ad = b + 6'd3; exp_q.push_back({ad, a3});
  endtask

  // Runs one transfer: en is raised in cycle 0, gpat[k] is gnt during cycle k,
  // inputs are scrambled in cycle scramble_at, done expected in cycle exp_done.
  task automatic run_xfer(input string tag, input logic [5:0] b,
                          input logic [7:0] a0, input logic [7:0] a1,
                          input logic [7:0] a2, input logic [7:0] a3,
                          input logic [15:0] gpat, input int scramble_at, input int exp_done);
    int done_at;
    result_baseaddr = b;
    c11 = a0; c12 = a1; c21 = a2; c22 = a3;
    gnt = gpat[0];
    en  = 1'b1;
    push_xfer(b, a0, a1, a2, a3);
    done_at = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      gnt = (k < 16) ? gpat[k] : 1'b1;
      if (k == 1) begin
        chk({tag, "_capt_state"}, 32'(dbg_state), 32'(S_CAPT));
        chk({tag, "_capt_busy_we"}, {30'd0, busy, we}, 32'b10);
      end
      if (k == scramble_at) begin
        c11 = ~a0;
        c12 = 8'h5A;
        result_baseaddr = b + 6'd7;
      end
      if (is_done_o === 1'b1) begin
        done_at = k;
        break;
      end
    end
    chk({tag, "_done_cycle"}, done_at, exp_done);
    chk({tag, "_beats_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_addr"},  32'(addr), 0);
    chk({tag, "_data"},  32'(data), 0);
    chk({tag, "_we"},    32'(we), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(is_done_o), 0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; en = 1'b0; gnt = 1'b0;
    result_baseaddr = '0; c11 = '0; c12 = '0; c21 = '0; c22 = '0;
    step(); step();
    chk_idle_outputs("reset");
    rst = 1'b1;
    step();

    // T1 basic
    run_xfer("t1", 6'h10, 8'h11, 8'h22, 8'h33, 8'h44, 16'hFFFF, -1, 6);
    en = 1'b0; step();
    chk("t1_clear_done", 32'(is_done_o), 0);

    // T2 stall on 2nd and 3rd write cycles (cycles 3 and 4)
    run_xfer("t2", 6'h10, 8'h11, 8'h22, 8'h33, 8'h44, 16'hFFE7, -1, 8);
    en = 1'b0; step();

    // T3 wrap plus input changes after capture
    run_xfer("t3", 6'h3E, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 16'hFFFF, 2, 6);
    en = 1'b0; step();

    // T4 abort after two accepted beats (second one in the abort cycle)
    result_baseaddr = 6'h20;
    c11 = 8'h01; c12 = 8'h02; c21 = 8'h03; c22 = 8'h04;
    gnt = 1'b1; en = 1'b1;
    exp_q.push_back({6'h20, 8'h01});
    exp_q.push_back({6'h21, 8'h02});
    step(); step(); step();
    en = 1'b0;
    step();
    chk_idle_outputs("t4_abort");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_no_done", 32'(is_done_o), 0);
    end
    chk("t4_beats_left", exp_q.size(), 0);
    exp_q.delete();
    run_xfer("t4_fresh", 6'h05, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 16'hFFFF, -1, 6);
    en = 1'b0; step();

    // T5 reset during S_WRITE
    result_baseaddr = 6'h30;
    c11 = 8'h55; c12 = 8'h66; c21 = 8'h77; c22 = 8'h88;
    gnt = 1'b1; en = 1'b1;
    exp_q.push_back({6'h30, 8'h55});
    step(); step(); step();
    chk("t5_in_write", 32'(dbg_state), 32'(S_WRITE));
    rst = 1'b0;
    step();
    chk_idle_outputs("t5_reset");
    chk("t5_beats_left", exp_q.size(), 0);
    exp_q.delete();
    rst = 1'b1;
    run_xfer("t5_restart", 6'h30, 8'h55, 8'h66, 8'h77, 8'h88, 16'hFFFF, -1, 6);

    // T6 done held while en stays high
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t6_done_hold", 32'(is_done_o), 1);
      chk("t6_busy_low", 32'(busy), 0);
      chk("t6_last_beat", {18'd0, addr, data}, {18'd0, 6'h33, 8'h88});
    end
    en = 1'b0;
    step();
    chk("t6_done_clear", 32'(is_done_o), 0);
    chk("t6_state_idle", 32'(dbg_state), 32'(S_IDLE));
    run_xfer("t6_restart", 6'h00, 8'hC0, 8'hFF, 8'hEE, 8'h01, 16'hFFFF, -1, 6);
    en = 1'b0; step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
